// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and helpers for the bit-serial adder.
// Exports: state_t (IDLE/RUN), cnt_w() bit-counter width.
package serial_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle of the bit-serial adder.
// master: start, sub, X, Y, cin out; busy, done, sum, cout, ovf in.
interface serial_adder_if #(
  parameter int W = 8
) ();

  logic         start;
  logic         sub;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, sub, X, Y, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, X, Y, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: combinational one-bit full adder.
// Ports: i_a, i_b, i_ci in; o_s sum, o_co majority carry out.
module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_a & i_ci) | (i_b & i_ci);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: W-bit LSB-first add/sub using one full-adder cell.
// Ports: clk, rst_n (async, active low), bus (serial_adder_if.slave).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = cnt_w(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t r_state;
  state_t w_next;

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-2:0]  r_res;
  logic [W-1:0]  r_sum;
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic          r_cout;
  logic          r_ovf;
  logic          r_done;

  logic          w_s;
  logic          w_c;
  logic          w_load;
  logic          w_step;
  logic          w_last;
  logic [W-1:0]  w_res;

  fa_cell u_fa (
    .i_a (r_a[0]),
    .i_b (r_b[0]),
    .i_ci(r_carry),
    .o_s (w_s),
    .o_co(w_c)
  );

  // New bit enters at the MSB; on the last bit this is the full result.
  assign w_res = {w_s, r_res};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_last = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load = 1'b1;
          w_next = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_cnt == LAST) begin
          w_last = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_a     <= bus.X;
        // Subtract as X + ~Y + 1: invert B, force carry in.
        r_b     <= bus.sub ? ~bus.Y : bus.Y;
        r_carry <= bus.sub | bus.cin;
        r_res   <= '0;
        r_cnt   <= '0;
      end else if (w_step) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_res   <= w_res[W-1:1];
        r_carry <= w_c;
        if (!w_last) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
      if (w_last) begin
        r_sum  <= w_res;
        r_cout <= w_c;
        // r_carry still holds the carry into the MSB here.
        r_ovf  <= r_carry ^ w_c;
      end
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule
